// File: rtl/keyplay.sv
// rtl/keyplay.sv - replays received keycodes as timed one-hot pushbutton presses
// Optional ASCII key decode: KEYPLAY_ASCII_EN
module keyplay #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 4,
    parameter int DEPTH       = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               rxdata,
    input  logic                     rxready,
    output logic                     rxclk,
    output logic [19:0]              pb,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf,
    output logic                     err
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNTW = (MAXC < 2) ? 1 : $clog2(MAXC);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PRESS = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [19:0]     pb_q, pb_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic            armed_q, armed_d;
    logic            rxclk_q, ovf_q, ovf_d, err_q, err_d;
    logic [4:0]      mem_q [DEPTH];

    logic       code_valid;
    logic [7:0] code_off;
    logic [7:0] code_diff;
    logic [4:0] code;
    logic       accept, wr_valid, wr_en, pop, full;

    always_comb begin
        code_valid = 1'b0;
        code_off   = 8'h00;
        if (rxdata <= 8'h13) begin
            code_valid = 1'b1;
        end
`ifdef KEYPLAY_ASCII_EN
        // Offsets move each ASCII range onto its keycode block.
        else if (rxdata >= 8'h30 && rxdata <= 8'h39) begin
            code_valid = 1'b1;
            code_off   = 8'h30;
        end else if (rxdata >= 8'h41 && rxdata <= 8'h46) begin
            code_valid = 1'b1;
            code_off   = 8'h37;
        end else if (rxdata >= 8'h61 && rxdata <= 8'h66) begin
            code_valid = 1'b1;
            code_off   = 8'h57;
        end else if (rxdata >= 8'h57 && rxdata <= 8'h5a) begin
            code_valid = 1'b1;
            code_off   = 8'h47;
        end else if (rxdata >= 8'h77 && rxdata <= 8'h7a) begin
            code_valid = 1'b1;
            code_off   = 8'h67;
        end
`endif
        code_diff = rxdata - code_off;
        code      = code_diff[4:0];
    end

    assign accept   = rxready & armed_q;
    assign wr_valid = accept & code_valid;
    assign pop      = (state_q == S_IDLE) && (count_q != '0);
    assign full     = (count_q == CW'(DEPTH));
    // A full FIFO still takes the write when the head leaves on the same edge.
    assign wr_en    = wr_valid & (~full | pop);

    always_comb begin
        armed_d = armed_q;
        if (!rxready) begin
            armed_d = 1'b1;
        end else if (accept) begin
            armed_d = 1'b0;
        end
        ovf_d = ovf_q | (wr_valid & full & ~pop);
        err_d = err_q | (accept & ~code_valid);
        count_d = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !wr_en) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pb_d    = pb_q;
        case (state_q)
            S_IDLE: begin
                pb_d = '0;
                if (pop) begin
                    pb_d    = 20'd1 << mem_q[rd_ptr_q];
                    cnt_d   = CNTW'(HOLD_CYCLES - 1);
                    state_d = S_PRESS;
                end
            end
            S_PRESS: begin
                if (cnt_q == '0) begin
                    pb_d    = '0;
                    cnt_d   = CNTW'(GAP_CYCLES - 1);
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                pb_d    = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            pb_q     <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            armed_q  <= 1'b1;
            rxclk_q  <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pb_q    <= pb_d;
            count_q <= count_d;
            armed_q <= armed_d;
            rxclk_q <= accept;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= code;
        end
    end

    assign rxclk = rxclk_q;
    assign pb    = pb_q;
    assign count = count_q;
    assign ovf   = ovf_q;
    assign err   = err_q;
    assign busy  = (count_q != '0) || (state_q != S_IDLE);
endmodule

// File: tb/tb_keyplay.sv
// tb/tb_keyplay.sv - directed self-checking bench for keyplay
module tb_keyplay;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rxdata = 8'h00;
    logic        rxready = 1'b0;
    logic        rxclk;
    logic [19:0] pb;
    logic        busy;
    logic [2:0]  count;
    logic        ovf;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [19:0] presses[$];
    int          gaps[$];
    int          nz_cycles, zrun, rxclk_pulses;
    logic        had_press;
    logic [19:0] prev_pb;

    keyplay #(.HOLD_CYCLES(4), .GAP_CYCLES(4), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .rxdata(rxdata), .rxready(rxready), .rxclk(rxclk),
        .pb(pb), .busy(busy), .count(count), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        presses.delete();
        gaps.delete();
        nz_cycles = 0;
        zrun = 0;
        rxclk_pulses = 0;
        had_press = 1'b0;
        prev_pb = pb;
    endtask

    // Advance one cycle, sample just after the edge and log press activity.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rxclk) rxclk_pulses++;
        if (pb != 0) begin
            nz_cycles++;
            if (prev_pb == 0) begin
                presses.push_back(pb);
                if (had_press) gaps.push_back(zrun);
            end
            had_press = 1'b1;
            zrun = 0;
        end else begin
            zrun++;
        end
        prev_pb = pb;
    endtask

    task automatic send(input logic [7:0] b);
        rxready = 1'b1;
        rxdata  = b;
        tick();
        rxready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
        repeat (3) tick();
    endtask

    int exp_cnt[7] = '{1, 1, 2, 3, 4, 4, 4};
    int exp_ovf[7] = '{0, 0, 0, 0, 0, 0, 1};

    initial begin
        clear_log();
        do_reset();
        check("reset_pb", pb, 0);
        check("reset_count", count, 0);
        check("reset_busy", busy, 0);
        check("reset_ovf", ovf, 0);
        check("reset_err", err, 0);
        check("reset_rxclk", rxclk, 0);

        // Single byte 0x13.
        clear_log();
        send(8'h13);
        check("single_rxclk", rxclk, 1);
        check("single_count", count, 1);
        check("single_pb_early", pb, 0);
        tick();
        check("single_rxclk_low", rxclk, 0);
        check("single_pb", pb, 20'h80000);
        check("single_count_pop", count, 0);
        check("single_busy", busy, 1);
        repeat (12) tick();
        check("single_hold", nz_cycles, 4);
        check("single_gap_ge5", {31'd0, zrun >= 5}, 1);
        check("single_npress", presses.size(), 1);
        check("single_idle", busy, 0);

        // Level held high is accepted once.
        clear_log();
        rxready = 1'b1;
        rxdata  = 8'h03;
        repeat (10) tick();
        rxready = 1'b0;
        repeat (14) tick();
        check("held_rxclk_pulses", rxclk_pulses, 1);
        check("held_npress", presses.size(), 1);
        check("held_pb", presses.size() > 0 ? presses[0] : 20'd0, 20'h00008);
        check("held_hold", nz_cycles, 4);

        // Asynchronous reset mid-press.
        clear_log();
        send(8'h03);
        tick();
        tick();
        check("mid_pb_before", pb, 20'h00008);
        #1 rst = 1'b0;
        #1;
        check("async_pb", pb, 0);
        check("async_count", count, 0);
        check("async_busy", busy, 0);
        #1 rst = 1'b1;
        tick();
        send(8'h05);
        check("post_rst_rxclk", rxclk, 1);
        tick();
        check("post_rst_pb", pb, 20'h00020);
        drain("post_rst_drain");

        // Burst: fill, full-with-pop, then overflow drop.
        clear_log();
        for (int i = 0; i < 7; i++) begin
            send(8'(i + 1));
            check($sformatf("burst_count%0d", i + 1), count, exp_cnt[i]);
            check($sformatf("burst_ovf%0d", i + 1), ovf, exp_ovf[i]);
            tick();
        end
        drain("burst_drain");
        check("burst_npress", presses.size(), 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("burst_order%0d", i), i < presses.size() ? presses[i] : 20'd0,
                  20'd1 << (i + 1));
        for (int i = 0; i < gaps.size(); i++)
            check($sformatf("burst_gap%0d", i), gaps[i], 5);
        check("burst_ovf_sticky", ovf, 1);

        // Invalid byte.
        do_reset();
        check("rst_clears_ovf", ovf, 0);
        clear_log();
        send(8'h20);
        check("bad_rxclk", rxclk, 1);
        check("bad_err", err, 1);
        check("bad_count", count, 0);
        repeat (8) tick();
        check("bad_npress", presses.size(), 0);
        check("bad_err_sticky", err, 1);

`ifdef KEYPLAY_ASCII_EN
        do_reset();
        clear_log();
        send(8'h78);
        tick();
        send(8'h37);
        tick();
        drain("ascii_drain");
        check("ascii_npress", presses.size(), 2);
        check("ascii_x", presses.size() > 0 ? presses[0] : 20'd0, 20'h20000);
        check("ascii_7", presses.size() > 1 ? presses[1] : 20'd0, 20'h00080);
        check("ascii_err", err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
